// File: rtl/alu_16b_pkg.sv
// Shared opcodes, operation-class encoding and width for the 16-bit ALU.
// ALU_16B_MULDIV_EN decides whether MUL/DIV count as arithmetic or as NOP.
package alu_16b_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_XNOR = 4'b1001;
    localparam logic [3:0] OP_EQ   = 4'b1010;
    localparam logic [3:0] OP_GT   = 4'b1011;
    localparam logic [3:0] OP_LT   = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_SHL  = 4'b1110;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    typedef enum logic [3:0] {
        CLS_NONE  = 4'b0000,
        CLS_ARITH = 4'b0001,
        CLS_LOGIC = 4'b0010,
        CLS_CMP   = 4'b0100,
        CLS_SHIFT = 4'b1000
    } op_class_e;

    function automatic op_class_e op_class(input logic [3:0] fun);
        op_class_e cls;
        case (fun)
            OP_ADD, OP_SUB:                      cls = CLS_ARITH;
`ifdef ALU_16B_MULDIV_EN
            OP_MUL, OP_DIV:                      cls = CLS_ARITH;
`endif
            OP_AND, OP_OR, OP_NAND,
            OP_NOR, OP_XOR, OP_XNOR:             cls = CLS_LOGIC;
            OP_EQ, OP_GT, OP_LT:                 cls = CLS_CMP;
            OP_SHR, OP_SHL:                      cls = CLS_SHIFT;
            default:                             cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_16b_if.sv
// Operand/function inputs and registered result/flag outputs of the ALU.
interface alu_16b_if;
    import alu_16b_pkg::*;

    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [3:0]        ALU_FUN;
    logic [DATA_W-1:0] ALU_OUT;
    logic              Carry_Flag;
    logic              Arith_Flag;
    logic              Logic_Flag;
    logic              CMP_Flag;
    logic              Shift_Flag;

    modport master (
        output A, B, ALU_FUN,
        input  ALU_OUT, Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag
    );

    modport slave (
        input  A, B, ALU_FUN,
        output ALU_OUT, Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag
    );

endinterface

// File: rtl/alu_16b_core.sv
// Combinational result, carry and class computation of the 16-bit ALU.
// MUL/DIV hardware exists only when ALU_16B_MULDIV_EN is defined.
module alu_16b_core
    import alu_16b_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        fun,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output op_class_e         cls
);

    logic [DATA_W:0] sum_s;
    logic [DATA_W:0] diff_s;

    // Bit 16 of the widened difference is the borrow (set when a < b).
    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} - {1'b0, b};

`ifdef ALU_16B_MULDIV_EN
    logic [DATA_W-1:0] prod_s;
    logic [DATA_W-1:0] quot_s;

    assign prod_s = a * b;
    assign quot_s = (b == 16'h0000) ? 16'hFFFF : (a / b);
`endif

    assign cls = op_class(fun);

    // Result and carry selection by function code.
    always_comb begin
        result = 16'h0000;
        carry  = 1'b0;
        case (fun)
            OP_ADD: begin
                result = sum_s[DATA_W-1:0];
                carry  = sum_s[DATA_W];
            end
            OP_SUB: begin
                result = diff_s[DATA_W-1:0];
                carry  = diff_s[DATA_W];
            end
`ifdef ALU_16B_MULDIV_EN
            OP_MUL:  result = prod_s;
            OP_DIV:  result = quot_s;
`endif
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            OP_EQ:   result = (a == b) ? 16'd1 : 16'd0;
            OP_GT:   result = (a > b)  ? 16'd2 : 16'd0;
            OP_LT:   result = (a < b)  ? 16'd3 : 16'd0;
            OP_SHR:  result = {1'b0, a[DATA_W-1:1]};
            OP_SHL:  result = {a[DATA_W-2:0], 1'b0};
            default: begin
                result = 16'h0000;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_16b.sv
// Registered 16-bit ALU: combinational core plus one output register stage.
// Define ALU_16B_MULDIV_EN to include the multiplier and divider.
module alu_16b
    import alu_16b_pkg::*;
(
    input  logic      CLK,
    input  logic      RST,
    alu_16b_if.slave  bus
);

    logic [DATA_W-1:0] result_s;
    logic              carry_s;
    op_class_e         cls_s;

    logic [DATA_W-1:0] alu_out_r;
    logic              carry_r;
    logic              arith_r;
    logic              logic_r;
    logic              cmp_r;
    logic              shift_r;

    alu_16b_core u_core (
        .a      (bus.A),
        .b      (bus.B),
        .fun    (bus.ALU_FUN),
        .result (result_s),
        .carry  (carry_s),
        .cls    (cls_s)
    );

    // Output register stage; reset clears everything immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            alu_out_r <= 16'h0000;
            carry_r   <= 1'b0;
            arith_r   <= 1'b0;
            logic_r   <= 1'b0;
            cmp_r     <= 1'b0;
            shift_r   <= 1'b0;
        end else begin
            alu_out_r <= result_s;
            carry_r   <= carry_s;
            arith_r   <= (cls_s == CLS_ARITH);
            logic_r   <= (cls_s == CLS_LOGIC);
            cmp_r     <= (cls_s == CLS_CMP);
            shift_r   <= (cls_s == CLS_SHIFT);
        end
    end

    assign bus.ALU_OUT    = alu_out_r;
    assign bus.Carry_Flag = carry_r;
    assign bus.Arith_Flag = arith_r;
    assign bus.Logic_Flag = logic_r;
    assign bus.CMP_Flag   = cmp_r;
    assign bus.Shift_Flag = shift_r;

endmodule

// File: tb/tb_alu_16b.sv
// Scoreboard bench for alu_16b: directed cases plus random ops vs an integer model.
module tb_alu_16b;

    typedef struct packed {
        logic [15:0] out;
        logic        c;
        logic        ar;
        logic        lo;
        logic        cm;
        logic        sh;
    } exp_t;

    logic CLK;
    logic RST;

    alu_16b_if bus ();

    alu_16b dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    exp_t  exp_q[$];
    string name_q[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model written from the operation table using plain integers.
    function automatic exp_t model(input longint a, input longint b, input int f);
        exp_t   e;
        longint r;
        int     arith_max;
        r = 0;
        e = '0;
`ifdef ALU_16B_MULDIV_EN
        arith_max = 3;
`else
        arith_max = 1;
`endif
        case (f)
            0: begin r = a + b; e.c = (r > 65535); r = r % 65536; end
            1: begin e.c = (a < b); r = (a - b + 65536) % 65536; end
`ifdef ALU_16B_MULDIV_EN
            2: r = (a * b) % 65536;
            3: r = (b == 0) ? 65535 : a / b;
`endif
            4: r = a & b;
            5: r = a | b;
            6: r = 65535 - (a & b);
            7: r = 65535 - (a | b);
            8: r = a ^ b;
            9: r = 65535 - (a ^ b);
            10: r = (a == b) ? 1 : 0;
            11: r = (a > b) ? 2 : 0;
            12: r = (a < b) ? 3 : 0;
            13: r = a / 2;
            14: r = (a * 2) % 65536;
            default: r = 0;
        endcase
        e.out = 16'(r);
        e.ar  = (f <= arith_max);
        e.lo  = (f >= 4 && f <= 9);
        e.cm  = (f >= 10 && f <= 12);
        e.sh  = (f == 13 || f == 14);
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t s;
        s = {bus.ALU_OUT, bus.Carry_Flag, bus.Arith_Flag, bus.Logic_Flag,
             bus.CMP_Flag, bus.Shift_Flag};
        return s;
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got out=%h c=%b a/l/c/s=%b%b%b%b, expected out=%h c=%b a/l/c/s=%b%b%b%b",
                     name, act.out, act.c, act.ar, act.lo, act.cm, act.sh,
                     exp.out, exp.c, exp.ar, exp.lo, exp.cm, exp.sh);
        end
    endtask

    // Drives one op at a falling edge and records what the next rising edge must show.
    task automatic issue(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] f);
        bus.A       = a;
        bus.B       = b;
        bus.ALU_FUN = f;
        exp_q.push_back(model(longint'(a), longint'(b), int'(f)));
        name_q.push_back(name);
        @(negedge CLK);
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'hFFFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: every result edge with an outstanding expectation is compared.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                check(name_q.pop_front(), sample(), exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t zero_e;
        exp_t hold_e;
        zero_e = '0;
        RST         = 1'b1;
        bus.A       = 16'h0000;
        bus.B       = 16'h0000;
        bus.ALU_FUN = 4'b0000;
        @(negedge CLK);
        @(negedge CLK);
        check("reset_state", sample(), zero_e);
        RST = 1'b0;

        issue("add_wrap",  16'hFFFF, 16'h0001, 4'b0000);
        issue("add_6_4",   16'h0006, 16'h0004, 4'b0000);
        issue("sub_4_6",   16'h0004, 16'h0006, 4'b0001);
        issue("sub_6_4",   16'h0006, 16'h0004, 4'b0001);
        issue("mul_2_2",   16'h0002, 16'h0002, 4'b0010);
        issue("div_2_2",   16'h0002, 16'h0002, 4'b0011);
        issue("div_5_0",   16'h0005, 16'h0000, 4'b0011);
        issue("and",       16'h0008, 16'h0007, 4'b0100);
        issue("or",        16'h0008, 16'h0007, 4'b0101);
        issue("nand",      16'h0008, 16'h0007, 4'b0110);
        issue("nor",       16'h0008, 16'h0007, 4'b0111);
        issue("xor",       16'h0008, 16'h0007, 4'b1000);
        issue("xnor",      16'h0008, 16'h0007, 4'b1001);
        issue("eq_4_4",    16'h0004, 16'h0004, 4'b1010);
        issue("eq_4_6",    16'h0004, 16'h0006, 4'b1010);
        issue("gt_6_4",    16'h0006, 16'h0004, 4'b1011);
        issue("gt_4_6",    16'h0004, 16'h0006, 4'b1011);
        issue("lt_4_6",    16'h0004, 16'h0006, 4'b1100);
        issue("lt_6_4",    16'h0006, 16'h0004, 4'b1100);
        issue("shr_2",     16'h0002, 16'hFFFF, 4'b1101);
        issue("shl_2",     16'h0002, 16'hFFFF, 4'b1110);
        issue("shl_8000",  16'h8000, 16'h0000, 4'b1110);
        issue("nop",       16'h1234, 16'h5678, 4'b1111);

        // Outputs must hold while inputs change between edges.
        bus.A       = 16'h00F0;
        bus.B       = 16'h0F00;
        bus.ALU_FUN = 4'b0101;
        hold_e      = model(64'h00F0, 64'h0F00, 5);
        @(posedge CLK);
        #2;
        bus.A       = 16'($urandom);
        bus.B       = 16'($urandom);
        bus.ALU_FUN = 4'b0000;
        #2;
        check("hold_between_edges", sample(), hold_e);
        @(negedge CLK);

        // Asynchronous reset in the middle of a stream of ops.
        issue("pre_reset_add", 16'h1000, 16'h2000, 4'b0000);
        bus.A       = 16'h7777;
        bus.B       = 16'h1111;
        bus.ALU_FUN = 4'b0001;
        #2;
        RST = 1'b1;
        #1;
        check("reset_async", sample(), zero_e);
        @(negedge CLK);
        check("reset_held", sample(), zero_e);
        RST = 1'b0;
        issue("post_reset_add", 16'h0006, 16'h0004, 4'b0000);

        for (int i = 0; i < 400; i++) begin
            issue("random_op", pick_operand(), pick_operand(), 4'($urandom_range(0, 15)));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge CLK);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
